// File: rtl/rom_boot_loader_pkg.sv
//------------------------------------------------------------------------------
// Module   : rom_boot_loader_pkg
// Purpose  : Shared constants and loader state encoding for rom_boot_loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rom_boot_loader_pkg;

   // Bytes that make up one little-endian instruction word
   localparam int c_BYTES_PER_WORD = 4;
   // Bytes in the word-count header that precedes the image
   localparam int c_HDR_BYTES      = 2;

   // Loader sequencing states
   typedef enum logic [2:0] {
      ST_LEN_LO  = 3'd0,
      ST_LEN_HI  = 3'd1,
      ST_DATA    = 3'd2,
      ST_WRITE   = 3'd3,
      ST_CSUM    = 3'd4,
      ST_LAUNCH  = 3'd5,
      ST_RUN     = 3'd6,
      ST_ERR     = 3'd7
   } boot_state_t;

   // Width of the header byte concatenation
   function automatic int hdr_bits();
      return 8 * c_HDR_BYTES;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rom_boot_loader_assembler.sv
//------------------------------------------------------------------------------
// Module   : rom_boot_loader_assembler
// Purpose  : Collects bytes into a 32-bit little-endian word. word_next shows
//            the word as it will look once byte_in is loaded; word_valid
//            flags the load that completes a word.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rom_boot_loader_assembler
   import rom_boot_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        load,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_next,
   output logic        word_valid
);

   localparam int                 c_CNT_W   = $clog2(c_BYTES_PER_WORD);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_END = c_CNT_W'(c_BYTES_PER_WORD - 1);

   logic [c_CNT_W-1:0] r_count;
   logic [31:8]        r_word;

   // Newest byte enters at the top, so after four loads byte 0 sits in [7:0]
   assign word_next  = {byte_in, r_word[31:8]};
   assign word_valid = load && (r_count == c_CNT_END);

   // Shift register and byte counter; counter wraps to 0 after a full word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_word  <= '0;
      end else if (clear) begin
         r_count <= '0;
         r_word  <= '0;
      end else if (load) begin
         r_count <= r_count + c_CNT_ONE;
         r_word  <= word_next[31:8];
      end
   end

endmodule

`default_nettype wire

// File: rtl/rom_boot_loader.sv
//------------------------------------------------------------------------------
// Module   : rom_boot_loader
// Purpose  : Receives a length-prefixed byte image, writes it word by word
//            into inst_rom through its load port, then releases the CPU.
//            Optional feature macro BOOT_CHECKSUM_EN: when defined, one XOR
//            checksum byte must follow the image before launch.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rom_boot_loader
   import rom_boot_loader_pkg::*;
#(
   parameter int          DEPTH_WORDS = 32,
   parameter logic [31:0] START_PC    = 32'h0000_0000,
   parameter int          LEN_W       = 16
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        write_enable,
   output logic [31:0] tb_inst,
   output logic [31:0] tb_addr,
   output logic        go,
   output logic        cpu_reset,
   output logic [31:0] start_pc,
   output logic        done,
   output logic        error
);

   localparam logic [LEN_W-1:0] c_DEPTH   = LEN_W'(DEPTH_WORDS);
   localparam logic [LEN_W-1:0] c_IDX_ONE = LEN_W'(1);

   boot_state_t      r_state;
   logic             r_rx_ready;
   logic             r_write_enable;
   logic [31:0]      r_tb_inst;
   logic [31:0]      r_tb_addr;
   logic             r_go;
   logic             r_cpu_reset;
   logic [31:0]      r_start_pc;
   logic             r_done;
   logic             r_error;
   logic [7:0]       r_len_lo;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_idx;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]       r_csum;
`endif

   logic             w_xfer;
   logic [LEN_W-1:0] w_hdr_len;
   logic [LEN_W-1:0] w_idx_inc;
   logic [31:0]      w_word_next;
   logic             w_word_valid;

   assign w_xfer    = rx_valid & r_rx_ready;
   assign w_hdr_len = LEN_W'({rx_data, r_len_lo});
   assign w_idx_inc = r_idx + c_IDX_ONE;

   rom_boot_loader_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (r_state == ST_LEN_LO),
      .load       (w_xfer && (r_state == ST_DATA)),
      .byte_in    (rx_data),
      .word_next  (w_word_next),
      .word_valid (w_word_valid)
   );

   // Loader FSM; every output is a register updated alongside the state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= ST_LEN_LO;
         r_rx_ready     <= 1'b0;
         r_write_enable <= 1'b0;
         r_tb_inst      <= '0;
         r_tb_addr      <= '0;
         r_go           <= 1'b0;
         r_cpu_reset    <= 1'b1;
         r_start_pc     <= START_PC;
         r_done         <= 1'b0;
         r_error        <= 1'b0;
         r_len_lo       <= '0;
         r_len          <= '0;
         r_idx          <= '0;
`ifdef BOOT_CHECKSUM_EN
         r_csum         <= '0;
`endif
      end else begin
         r_write_enable <= 1'b0;
         case (r_state)
            ST_LEN_LO: begin
               r_rx_ready <= 1'b1;
               r_idx      <= '0;
`ifdef BOOT_CHECKSUM_EN
               r_csum     <= '0;
`endif
               if (w_xfer) begin
                  r_len_lo <= rx_data;
                  r_state  <= ST_LEN_HI;
               end
            end
            ST_LEN_HI: begin
               if (w_xfer) begin
                  r_len <= w_hdr_len;
                  // Full-width compare so oversize counts are never aliased
                  if (w_hdr_len > c_DEPTH) begin
                     r_state    <= ST_ERR;
                     r_rx_ready <= 1'b0;
                     r_error    <= 1'b1;
                  end else if (w_hdr_len == '0) begin
`ifdef BOOT_CHECKSUM_EN
                     r_state    <= ST_CSUM;
`else
                     r_state    <= ST_LAUNCH;
                     r_rx_ready <= 1'b0;
                     r_go       <= 1'b1;
                     r_start_pc <= START_PC;
`endif
                  end else begin
                     r_state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (w_xfer) begin
`ifdef BOOT_CHECKSUM_EN
                  r_csum <= r_csum ^ rx_data;
`endif
                  if (w_word_valid) begin
                     r_state        <= ST_WRITE;
                     r_rx_ready     <= 1'b0;
                     r_write_enable <= 1'b1;
                     r_tb_inst      <= w_word_next;
                     r_tb_addr      <= 32'({r_idx, 2'b00});
                  end
               end
            end
            ST_WRITE: begin
               r_idx <= w_idx_inc;
               if (w_idx_inc == r_len) begin
`ifdef BOOT_CHECKSUM_EN
                  r_state    <= ST_CSUM;
                  r_rx_ready <= 1'b1;
`else
                  r_state    <= ST_LAUNCH;
                  r_go       <= 1'b1;
                  r_start_pc <= START_PC;
`endif
               end else begin
                  r_state    <= ST_DATA;
                  r_rx_ready <= 1'b1;
               end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: begin
               if (w_xfer) begin
                  r_rx_ready <= 1'b0;
                  if (rx_data == r_csum) begin
                     r_state    <= ST_LAUNCH;
                     r_go       <= 1'b1;
                     r_start_pc <= START_PC;
                  end else begin
                     r_state <= ST_ERR;
                     r_error <= 1'b1;
                  end
               end
            end
`endif
            ST_LAUNCH: begin
               // go has already been high for one cycle; now free the CPU
               r_state     <= ST_RUN;
               r_cpu_reset <= 1'b0;
               r_done      <= 1'b1;
            end
            ST_RUN: begin
               r_rx_ready <= 1'b0;
            end
            ST_ERR: begin
               r_rx_ready  <= 1'b0;
               r_go        <= 1'b0;
               r_cpu_reset <= 1'b1;
            end
            default: begin
               r_state    <= ST_ERR;
               r_rx_ready <= 1'b0;
               r_error    <= 1'b1;
            end
         endcase
      end
   end

   assign rx_ready     = r_rx_ready;
   assign write_enable = r_write_enable;
   assign tb_inst      = r_tb_inst;
   assign tb_addr      = r_tb_addr;
   assign go           = r_go;
   assign cpu_reset    = r_cpu_reset;
   assign start_pc     = r_start_pc;
   assign done         = r_done;
   assign error        = r_error;

endmodule

`default_nettype wire

// File: tb/tb_rom_boot_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_rom_boot_loader
// Purpose  : Self-checking bench for rom_boot_loader; images are checked
//            against a byte-stream reference model. Honours BOOT_CHECKSUM_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rom_boot_loader;

   localparam int c_DEPTH = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        write_enable;
   logic [31:0] tb_inst;
   logic [31:0] tb_addr;
   logic        go;
   logic        cpu_reset;
   logic [31:0] start_pc;
   logic        done;
   logic        error;

   rom_boot_loader #(
      .DEPTH_WORDS (c_DEPTH),
      .START_PC    (32'h0000_0000),
      .LEN_W       (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .write_enable (write_enable),
      .tb_inst      (tb_inst),
      .tb_addr      (tb_addr),
      .go           (go),
      .cpu_reset    (cpu_reset),
      .start_pc     (start_pc),
      .done         (done),
      .error        (error)
   );

   always #5 clk = ~clk;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   logic [7:0]  byte_q[$];
   logic [63:0] wq[$];
   int          wcyc[$];
   int          go_cyc;
   int          rel_cyc;
   int          launches;
   bit          go_seen;

   logic [63:0] exp_w[$];
   bit          exp_launch;
   bit          exp_err;
   int          exp_consumed;
   bit          exp_last_data;

   always @(posedge clk) cyc++;

   // Observe DUT outputs mid-cycle
   always @(negedge clk) begin
      if (write_enable) begin
         wq.push_back({tb_addr, tb_inst});
         wcyc.push_back(cyc);
      end
      if (go && !go_seen) begin
         go_seen = 1'b1;
         if (go_cyc < 0) go_cyc = cyc;
         launches++;
      end
      if (!go) go_seen = 1'b0;
      if (!cpu_reset && rel_cyc < 0) rel_cyc = cyc;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic clear_logs();
      wq.delete();
      wcyc.delete();
      go_cyc   = -1;
      rel_cyc  = -1;
      launches = 0;
      go_seen  = 1'b0;
   endtask

   task automatic reset_dut(input bit chk);
      @(negedge clk);
      reset    = 1'b1;
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      if (chk) begin
         check("rst_rx_ready", 32'(rx_ready), 0);
         check("rst_we", 32'(write_enable), 0);
         check("rst_inst", tb_inst, 0);
         check("rst_addr", tb_addr, 0);
         check("rst_go", 32'(go), 0);
         check("rst_cpu_reset", 32'(cpu_reset), 1);
         check("rst_start_pc", start_pc, 0);
         check("rst_done", 32'(done), 0);
         check("rst_error", 32'(error), 0);
      end
      reset = 1'b0;
      #1;
      clear_logs();
      if (chk) check("rst_ready_low_after_release", 32'(rx_ready), 0);
      @(negedge clk);
      if (chk) check("rst_ready_rises", 32'(rx_ready), 1);
   endtask

   // Append the XOR of all bytes after the header (optionally corrupted)
   task automatic finish_image(input bit bad);
      logic [7:0] x;
      x = 8'h00;
      for (int i = 2; i < byte_q.size(); i++) x ^= byte_q[i];
      byte_q.push_back(bad ? (x ^ 8'h01) : x);
   endtask

   task automatic build_image(input int n, input bit bad);
      byte_q.delete();
      byte_q.push_back(8'(n));
      byte_q.push_back(8'(n >> 8));
      for (int i = 0; i < 4 * n; i++) byte_q.push_back(8'($urandom));
      finish_image(bad);
   endtask

   // Reference: interpret byte_q by the loader's rules
   task automatic model();
      int         n;
      logic [7:0] x;
      exp_w.delete();
      x = 8'h00;
      n = int'(byte_q[0]) + 256 * int'(byte_q[1]);
      exp_last_data = 1'b0;
      if (n > c_DEPTH) begin
         exp_err = 1'b1; exp_launch = 1'b0; exp_consumed = 2;
         return;
      end
      for (int k = 0; k < n; k++) begin
         exp_w.push_back({32'(4 * k), byte_q[2+4*k+3], byte_q[2+4*k+2],
                          byte_q[2+4*k+1], byte_q[2+4*k]});
         for (int j = 0; j < 4; j++) x ^= byte_q[2+4*k+j];
      end
      exp_consumed  = 2 + 4 * n;
      exp_last_data = (n > 0);
`ifdef BOOT_CHECKSUM_EN
      exp_consumed  = exp_consumed + 1;
      exp_last_data = 1'b0;
      exp_launch    = (byte_q[2+4*n] == x);
      exp_err       = !exp_launch;
`else
      exp_launch = 1'b1;
      exp_err    = 1'b0;
`endif
   endtask

   // Offer byte_q in order; stops at the first byte that is never accepted
   task automatic send_stream(input bit rnd, output int n_acc, output int t_last);
      int  waited;
      bit  took;
      n_acc  = 0;
      t_last = -1;
      foreach (byte_q[i]) begin
         waited = 0;
         took   = 1'b0;
         while (!took) begin
            @(negedge clk);
            rx_data  = byte_q[i];
            rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (rx_valid && rx_ready) begin
               took = 1'b1;
               n_acc++;
               t_last = cyc;
            end else if (++waited > 40) begin
               rx_valid = 1'b0;
               return;
            end
         end
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic run_image(input string tag, input bit rnd, input bit rst_chk);
      int n_acc, t_last, exp_go, exp_rel;
      reset_dut(rst_chk);
      model();
      send_stream(rnd, n_acc, t_last);
      repeat (6) @(negedge clk);
      #1;
      check({tag, "_consumed"}, n_acc, exp_consumed);
      check({tag, "_nwrites"}, wq.size(), exp_w.size());
      for (int k = 0; k < exp_w.size() && k < wq.size(); k++) begin
         check($sformatf("%s_addr%0d", tag, k), wq[k][63:32], exp_w[k][63:32]);
         check($sformatf("%s_inst%0d", tag, k), wq[k][31:0], exp_w[k][31:0]);
      end
      exp_go  = exp_launch ? t_last + (exp_last_data ? 2 : 1) : -1;
      exp_rel = exp_launch ? exp_go + 1 : -1;
      if (exp_last_data && wcyc.size() > 0)
         check({tag, "_last_we_cycle"}, wcyc[wcyc.size()-1], t_last + 1);
      check({tag, "_go_cycle"}, go_cyc, exp_go);
      check({tag, "_release_cycle"}, rel_cyc, exp_rel);
      check({tag, "_launches"}, launches, exp_launch ? 1 : 0);
      check({tag, "_go"}, 32'(go), 32'(exp_launch));
      check({tag, "_done"}, 32'(done), 32'(exp_launch));
      check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_launch));
      check({tag, "_error"}, 32'(error), 32'(exp_err));
      check({tag, "_rx_ready"}, 32'(rx_ready), 0);
      check({tag, "_start_pc"}, start_pc, 0);
   endtask

   initial begin
      logic [7:0] t1[$];
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      clear_logs();

      // Directed two-word image; trailing byte is the checksum or ignored junk
      t1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      byte_q = t1;
      finish_image(1'b0);
      byte_q.push_back(8'hAA);
      run_image("t1", 1'b0, 1'b1);
      check("t1_word0_const", (wq.size() > 0) ? wq[0][31:0] : 32'hDEAD_BEEF, 32'h0000_0013);
      check("t1_word1_const", (wq.size() > 1) ? wq[1][31:0] : 32'hDEAD_BEEF, 32'h0010_0093);
      check("t1_addr1_const", (wq.size() > 1) ? wq[1][63:32] : 32'hDEAD_BEEF, 32'h0000_0004);

      // Empty image
      byte_q = '{8'h00, 8'h00};
      finish_image(1'b0);
      run_image("empty", 1'b0, 1'b0);

      // Oversize headers: one past depth, and one needing the high byte
      byte_q = '{8'h21, 8'h00, 8'h11, 8'h22};
      run_image("over33", 1'b0, 1'b0);
      byte_q = '{8'h00, 8'h01, 8'h11, 8'h22};
      run_image("over256", 1'b0, 1'b0);

      // Exactly full ROM
      build_image(c_DEPTH, 1'b0);
      run_image("full", 1'b1, 1'b0);

      // Two-word image with random rx_valid gaps
      byte_q = t1;
      finish_image(1'b0);
      run_image("t1_gaps", 1'b1, 1'b0);

      // Reset after two bytes of the first word, then a clean reload
      reset_dut(1'b0);
      byte_q = '{8'h02, 8'h00, 8'h13, 8'h00};
      begin
         int a, t;
         send_stream(1'b0, a, t);
      end
      byte_q = t1;
      finish_image(1'b0);
      run_image("midreset", 1'b1, 1'b1);

`ifdef BOOT_CHECKSUM_EN
      byte_q = t1;
      finish_image(1'b1);
      run_image("bad_csum", 1'b0, 1'b0);
`endif

      // Random images
      for (int r = 0; r < 5; r++) begin
         build_image($urandom_range(1, 8), 1'($urandom_range(0, 3) == 0));
         run_image($sformatf("rand%0d", r), 1'b1, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
